load_store_unit: RTL

//  Sits between the execute stage and the dcache. Accepts one load/store per transaction and issues a word-aligned

---
 rtl/load_store_unit.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: bridges execute and the dcache for RV32I loads and stores.
// One op in flight; misaligned, illegal and timed-out accesses become precise exceptions.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        ex_is_store,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [4:0]  ex_rd,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        exc_valid,
    output logic [3:0]  exc_cause,
    output logic [31:0] exc_addr,
    output logic        dc_valid,
    output logic [31:0] dc_addr,
    output logic [31:0] dc_wdata,
    output logic [3:0]  dc_byte_enable,
    input  logic        dc_ready,
    input  logic [31:0] dc_rdata
);

    localparam int CW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TLAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CW-1:0] CNT_LAST = CW'(TLAST);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
    localparam logic [3:0] CAUSE_LD_MIS  = 4'd4;
    localparam logic [3:0] CAUSE_LD_FLT  = 4'd5;
    localparam logic [3:0] CAUSE_ST_MIS  = 4'd6;
    localparam logic [3:0] CAUSE_ST_FLT  = 4'd7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        EXC    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          is_store_q, is_store_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [4:0]    rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    cause_q, cause_d;
    logic [31:0]   wb_data_q, wb_data_d;
    logic          wb_we_q, wb_we_d;

    logic          illegal;
    logic          misaligned;
    logic [31:0]   st_wdata;
    logic [3:0]    st_be;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_data;

    // Classify the incoming op; illegal takes priority over misaligned.
    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        unique case (ex_funct3)
            F3_B:  illegal = 1'b0;
            F3_H:  misaligned = ex_addr[0];
            F3_W:  misaligned = |ex_addr[1:0];
            F3_BU: illegal = ex_is_store;
            F3_HU: begin
                illegal    = ex_is_store;
                misaligned = ex_addr[0];
            end
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        st_wdata = wdata_q;
        st_be    = 4'b1111;
        unique case (1'b1)
            (funct3_q[1:0] == 2'b00): begin
                st_wdata = {4{wdata_q[7:0]}};
                st_be    = 4'b0001 << addr_q[1:0];
            end
            (funct3_q[1:0] == 2'b01): begin
                st_wdata = {2{wdata_q[15:0]}};
                st_be    = 4'b0011 << addr_q[1:0];
            end
            default: begin
                st_wdata = wdata_q;
                st_be    = 4'b1111;
            end
        endcase
    end

    assign ld_byte = dc_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign ld_half = dc_rdata[{addr_q[1], 4'b0000} +: 16];

    always_comb begin
        ld_data = dc_rdata;
        unique case (funct3_q)
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_data = {24'h0, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_data = {16'h0, ld_half};
            default: ld_data = dc_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        cause_d    = cause_q;
        wb_data_d  = wb_data_q;
        wb_we_d    = wb_we_q;
        unique case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    is_store_d = ex_is_store;
                    funct3_d   = ex_funct3;
                    addr_d     = ex_addr;
                    wdata_d    = ex_wdata;
                    rd_d       = ex_rd;
                    if (illegal) begin
                        cause_d = CAUSE_ILLEGAL;
                        state_d = EXC;
                    end else if (misaligned) begin
                        cause_d = ex_is_store ? CAUSE_ST_MIS : CAUSE_LD_MIS;
                        state_d = EXC;
                    end else begin
                        cnt_d   = '0;
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                // A response in the final cycle beats the timeout.
                if (dc_ready) begin
                    wb_data_d = is_store_q ? 32'h0 : ld_data;
                    wb_we_d   = !is_store_q && (rd_q != 5'd0);
                    state_d   = RESP;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
                    cause_d = is_store_q ? CAUSE_ST_FLT : CAUSE_LD_FLT;
                    state_d = EXC;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: state_d = IDLE;
            EXC:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            is_store_q <= 1'b0;
            funct3_q   <= 3'b000;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            rd_q       <= 5'd0;
            cnt_q      <= '0;
            cause_q    <= 4'd0;
            wb_data_q  <= 32'h0;
            wb_we_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            cause_q    <= cause_d;
            wb_data_q  <= wb_data_d;
            wb_we_q    <= wb_we_d;
        end
    end

    always_comb begin
        ex_ready       = (state_q == IDLE);
        dc_valid       = (state_q == ACCESS);
        dc_addr        = dc_valid ? {addr_q[31:2], 2'b00} : 32'h0;
        dc_wdata       = (dc_valid && is_store_q) ? st_wdata : 32'h0;
        dc_byte_enable = (dc_valid && is_store_q) ? st_be : 4'b0000;
        wb_valid       = (state_q == RESP);
        wb_we          = wb_valid && wb_we_q;
        wb_rd          = wb_valid ? rd_q : 5'd0;
        wb_data        = wb_valid ? wb_data_q : 32'h0;
        exc_valid      = (state_q == EXC);
        exc_cause      = exc_valid ? cause_q : 4'd0;
        exc_addr       = exc_valid ? addr_q : 32'h0;
    end

endmodule
